// File: rtl/spi_pkg.sv
// Shared SPI definitions: initiator FSM states and the command-byte layout
// understood by both the initiator and the responder.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SHIFT,
      HOLD,
      TRAIL,
      GAP
   } spi_state_e;

   localparam int unsigned ADDR_HI = 7;
   localparam int unsigned ADDR_LO = 6;
   localparam int unsigned OP_HI   = 5;
   localparam int unsigned OP_LO   = 4;
   localparam int unsigned DATA_HI = 3;
   localparam int unsigned DATA_LO = 0;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;

   function automatic logic [7:0] mk_cmd(input logic [1:0] addr,
                                         input logic [1:0] op,
                                         input logic [3:0] data);
      logic [7:0] cmd;
      cmd                  = '0;
      cmd[ADDR_HI:ADDR_LO] = addr;
      cmd[OP_HI:OP_LO]     = op;
      cmd[DATA_HI:DATA_LO] = data;
      return cmd;
   endfunction

endpackage

// File: rtl/spi_master_tx.sv
// Mode-0 SPI initiator, MSB first, with a byte valid/ready front end;
// tx_last closes the transaction, otherwise SEL stays low in HOLD.
module spi_master_tx
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned LEAD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic       ico_clk,
   input  logic       rst,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       spi_sclk,
   output logic       spi_sel,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   localparam int unsigned PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_MAX = (LEAD_CYCLES > GAP_CYCLES) ? LEAD_CYCLES : GAP_CYCLES;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
   localparam logic [CW-1:0] LEAD_LAST = CW'(LEAD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

   spi_state_e    state_q;
   logic          tx_ready_q;
   logic          rx_valid_q;
   logic [7:0]    rx_data_q;
   logic          sclk_q;
   logic          sel_q;
   logic          mosi_q;
   logic [6:0]    tx_sh_q;
   logic [6:0]    rx_sh_q;
   logic          last_q;
   logic [PW-1:0] ph_q;
   logic [2:0]    bit_q;
   logic [CW-1:0] cnt_q;

   logic          accept;
   logic [7:0]    rx_shift_d;

   assign accept     = tx_valid && tx_ready_q;
   assign rx_shift_d = {rx_sh_q, spi_miso};

   always_ff @(posedge ico_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_ready_q <= 1'b1;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         sclk_q     <= 1'b0;
         sel_q      <= 1'b1;
         mosi_q     <= 1'b0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         last_q     <= 1'b0;
         ph_q       <= '0;
         bit_q      <= '0;
         cnt_q      <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q    <= LEAD;
                  tx_ready_q <= 1'b0;
                  sel_q      <= 1'b0;
                  mosi_q     <= tx_data[7];
                  tx_sh_q    <= tx_data[6:0];
                  last_q     <= tx_last;
                  cnt_q      <= '0;
               end
            end

            LEAD: begin
               if (cnt_q == LEAD_LAST) begin
                  state_q <= SHIFT;
                  cnt_q   <= '0;
                  ph_q    <= '0;
                  bit_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            SHIFT: begin
               if (ph_q != PH_LAST) begin
                  ph_q <= ph_q + 1'b1;
               end else begin
                  ph_q <= '0;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else begin
                     // Last cycle of the high phase: sample MISO, then fall.
                     sclk_q  <= 1'b0;
                     rx_sh_q <= rx_shift_d[6:0];
                     if (bit_q == 3'd7) begin
                        rx_data_q  <= rx_shift_d;
                        rx_valid_q <= 1'b1;
                        if (last_q) begin
                           state_q <= TRAIL;
                           cnt_q   <= '0;
                        end else begin
                           state_q    <= HOLD;
                           tx_ready_q <= 1'b1;
                        end
                     end else begin
                        bit_q   <= bit_q + 1'b1;
                        mosi_q  <= tx_sh_q[6];
                        tx_sh_q <= {tx_sh_q[5:0], 1'b0};
                     end
                  end
               end
            end

            HOLD: begin
               if (accept) begin
                  state_q    <= SHIFT;
                  tx_ready_q <= 1'b0;
                  mosi_q     <= tx_data[7];
                  tx_sh_q    <= tx_data[6:0];
                  last_q     <= tx_last;
                  ph_q       <= '0;
                  bit_q      <= '0;
               end
            end

            TRAIL: begin
               if (cnt_q == LEAD_LAST) begin
                  state_q <= GAP;
                  sel_q   <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_q    <= IDLE;
                  tx_ready_q <= 1'b1;
                  cnt_q      <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: begin
               state_q    <= IDLE;
               tx_ready_q <= 1'b1;
               sel_q      <= 1'b1;
               sclk_q     <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready = tx_ready_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign busy     = (state_q != IDLE);
   assign spi_sclk = sclk_q;
   assign spi_sel  = sel_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: table of single-byte transfers, directed corner
// sequences and random multi-byte transactions against a transaction model.
module tb_spi_master_tx;
   import spi_pkg::*;

   localparam int unsigned D = 4;
   localparam int unsigned L = 4;
   localparam int unsigned G = 4;

   logic ico_clk = 1'b0;
   always #5 ico_clk = ~ico_clk;

   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_last = 1'b0;
   logic       tx_ready, rx_valid, busy, spi_sclk, spi_sel, spi_mosi;
   logic [7:0] rx_data;
   logic       spi_miso = 1'b0;

   logic       tx_valid2 = 1'b0;
   logic [7:0] tx_data2 = '0;
   logic       tx_last2 = 1'b0;
   logic       tx_ready2, rx_valid2, busy2, sclk2, sel2, mosi2;
   logic [7:0] rx_data2;

   spi_master_tx #(.CLK_DIV(D), .LEAD_CYCLES(L), .GAP_CYCLES(G)) dut (
      .ico_clk(ico_clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data),
      .busy(busy), .spi_sclk(spi_sclk), .spi_sel(spi_sel), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso)
   );

   spi_master_tx #(.CLK_DIV(2), .LEAD_CYCLES(1), .GAP_CYCLES(1)) dut2 (
      .ico_clk(ico_clk), .rst(rst), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
      .tx_data(tx_data2), .tx_last(tx_last2), .rx_valid(rx_valid2), .rx_data(rx_data2),
      .busy(busy2), .spi_sclk(sclk2), .spi_sel(sel2), .spi_mosi(mosi2),
      .spi_miso(mosi2)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_assert++;
      n_fail++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Bus observer and behavioural responder for the default-parameter DUT.
   int         cyc = 0;
   logic       sclk_p = 1'b0, sel_p = 1'b1, mosi_p = 1'b0, rxv_p = 1'b0;
   int         rise_c = 0, fall_c = 0;
   bit         fall_ok = 1'b0;
   bit         mosi_bits[$];
   int         high_runs[$], low_runs[$], sel_fall_c[$], sel_rise_c[$];
   logic [7:0] rx_got[$];
   int         rxv_long = 0, mosi_glitch = 0;
   bit         resp_bits[64];
   int         rptr = 0;

   always begin
      @(posedge ico_clk);
      #1;
      cyc++;
      if (sel_p && !spi_sel) begin
         sel_fall_c.push_back(cyc);
         fall_ok  = 1'b0;
         spi_miso = resp_bits[0];
         rptr     = 1;
      end
      if (!sclk_p && spi_sclk) begin
         mosi_bits.push_back(spi_mosi);
         if (fall_ok) low_runs.push_back(cyc - fall_c);
         rise_c = cyc;
      end
      if (sclk_p && !spi_sclk) begin
         high_runs.push_back(cyc - rise_c);
         fall_c  = cyc;
         fall_ok = 1'b1;
         if (!spi_sel) begin
            spi_miso = (rptr < 64) ? resp_bits[rptr] : 1'b0;
            rptr++;
         end
      end
      if (sclk_p && spi_sclk && (spi_mosi != mosi_p)) mosi_glitch++;
      if (!sel_p && spi_sel) sel_rise_c.push_back(cyc);
      if (rx_valid) rx_got.push_back(rx_data);
      if (rxv_p && rx_valid) rxv_long++;
      sclk_p = spi_sclk;
      sel_p  = spi_sel;
      mosi_p = spi_mosi;
      rxv_p  = rx_valid;
   end

   int         cyc2 = 0;
   logic       sclk2_p = 1'b0;
   int         rise2[$];
   logic [7:0] rx2_got[$];

   always begin
      @(posedge ico_clk);
      #1;
      cyc2++;
      if (!sclk2_p && sclk2) rise2.push_back(cyc2);
      if (rx_valid2) rx2_got.push_back(rx_data2);
      sclk2_p = sclk2;
   end

   logic [7:0] txb[4];
   logic [7:0] rsp[4];
   int         gapd[4];
   int         last_took = 0;

   task automatic wait_ready(input string tag);
      int g = 0;
      while (!tx_ready && g < 2000) begin
         @(negedge ico_clk);
         g++;
      end
      if (g >= 2000) timeout({tag, " tx_ready"});
   endtask

   // Drives n bytes and checks the whole transaction against the byte-level model.
   task automatic run_txn(input string tag, input int n, input bit stream);
      int b_bits, b_rx, b_hr, b_lr, b_sf, b_sr, g0, l0, t0, took, holds, guard, bad;
      int hk[4];
      logic [7:0] got;
      b_bits = mosi_bits.size(); b_rx = rx_got.size(); b_hr = high_runs.size();
      b_lr = low_runs.size(); b_sf = sel_fall_c.size(); b_sr = sel_rise_c.size();
      g0 = mosi_glitch; l0 = rxv_long;
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < 8; i++)
            resp_bits[8*k+i] = (k < n) ? rsp[k][7-i] : 1'b0;
      for (int i = 32; i < 64; i++) resp_bits[i] = 1'b0;
      @(negedge ico_clk);
      tx_valid = 1'b1; tx_data = txb[0]; tx_last = (n == 1);
      wait_ready(tag);
      t0 = cyc;
      holds = 0;
      hk[0] = 0;
      for (int k = 1; k < n; k++) begin
         @(negedge ico_clk);
         hk[k] = stream ? 0 : gapd[k];
         if (!stream) begin
            tx_valid = 1'b0;
            guard = 0;
            while (!rx_valid && guard < 1000) begin
               @(negedge ico_clk);
               guard++;
            end
            if (guard >= 1000) timeout({tag, " rx_valid"});
            repeat (gapd[k]) @(negedge ico_clk);
            tx_valid = 1'b1;
         end
         tx_data = txb[k]; tx_last = (k == n - 1);
         wait_ready(tag);
         holds += 1 + hk[k];
      end
      @(negedge ico_clk);
      tx_valid = 1'b0;
      wait_ready(tag);
      took = cyc - t0;
      last_took = took;

      chk({tag, " accept-to-ready cycles"}, took, 1 + 2*L + 16*D*n + holds + G);
      chk({tag, " sel falls"}, sel_fall_c.size() - b_sf, 1);
      chk({tag, " sel rises"}, sel_rise_c.size() - b_sr, 1);
      if (sel_rise_c.size() > b_sr)
         chk({tag, " sel rise offset"}, sel_rise_c[b_sr] - t0, 1 + 2*L + 16*D*n + holds);
      chk({tag, " rx_valid count"}, rx_got.size() - b_rx, n);
      chk({tag, " mosi bit count"}, mosi_bits.size() - b_bits, 8*n);
      for (int k = 0; k < n; k++) begin
         if (rx_got.size() > b_rx + k)
            chk($sformatf("%s rx byte %0d", tag, k), rx_got[b_rx+k], rsp[k]);
         if (mosi_bits.size() >= b_bits + 8*(k+1)) begin
            got = '0;
            for (int i = 0; i < 8; i++) got = {got[6:0], mosi_bits[b_bits+8*k+i]};
            chk($sformatf("%s mosi byte %0d", tag, k), got, txb[k]);
         end
      end
      bad = 0;
      for (int j = b_hr; j < high_runs.size(); j++) if (high_runs[j] != D) bad++;
      chk({tag, " sclk high phases not CLK_DIV"}, bad, 0);
      chk({tag, " sclk low run count"}, low_runs.size() - b_lr, 8*n - 1);
      bad = 0;
      for (int j = 0; j < low_runs.size() - b_lr; j++) begin
         if (((j + 1) % 8) == 0) begin
            if (low_runs[b_lr+j] != D + 1 + hk[(j+1)/8]) bad++;
         end else if (low_runs[b_lr+j] != D) bad++;
      end
      chk({tag, " sclk low runs"}, bad, 0);
      chk({tag, " mosi change while sclk high"}, mosi_glitch - g0, 0);
      chk({tag, " rx_valid wider than 1"}, rxv_long - l0, 0);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [7:0] resp;
      logic [7:0] exp_rx;
      int         exp_cyc;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_bits, b_rx, b_sf, t0, g, n;
      logic [7:0] got;
      bit stream;

      vecs[0] = '{8'h05, 8'h3C, 8'h3C, 77};
      vecs[1] = '{8'h00, 8'hFF, 8'hFF, 77};
      vecs[2] = '{8'hFF, 8'h00, 8'h00, 77};
      vecs[3] = '{8'h80, 8'h01, 8'h01, 77};
      vecs[4] = '{8'h01, 8'h80, 8'h80, 77};

      rst = 1'b1;
      repeat (3) @(negedge ico_clk);
      chk("reset sclk", spi_sclk, 1'b0);
      chk("reset sel", spi_sel, 1'b1);
      chk("reset mosi", spi_mosi, 1'b0);
      chk("reset tx_ready", tx_ready, 1'b1);
      chk("reset rx_valid", rx_valid, 1'b0);
      chk("reset rx_data", rx_data, 8'h00);
      chk("reset busy", busy, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge ico_clk);

      foreach (vecs[v]) begin
         txb[0] = vecs[v].data;
         rsp[0] = vecs[v].resp;
         run_txn($sformatf("vec%0d", v), 1, 1'b0);
         if (rx_got.size() > 0) chk($sformatf("vec%0d table rx", v), rx_got[$], vecs[v].exp_rx);
         chk($sformatf("vec%0d table cycles", v), last_took, vecs[v].exp_cyc);
      end

      txb[0] = mk_cmd(2'd0, OP_READ, 4'd0); txb[1] = 8'h00;
      rsp[0] = 8'h00; rsp[1] = 8'h5A; gapd[1] = 2;
      run_txn("read", 2, 1'b0);
      if (rx_got.size() > 0) chk("read second rx_data", rx_got[$], 8'h5A);

      txb[0] = 8'hA5; txb[1] = 8'h3C; txb[2] = 8'hFF;
      rsp[0] = 8'h12; rsp[1] = 8'h34; rsp[2] = 8'h56;
      run_txn("hold stream", 3, 1'b1);

      // Offer 0x77 while a byte is shifting; it must be ignored.
      b_bits = mosi_bits.size(); b_sf = sel_fall_c.size();
      @(negedge ico_clk);
      tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b1;
      wait_ready("busy");
      @(negedge ico_clk);
      tx_valid = 1'b0;
      g = 0;
      while (mosi_bits.size() < b_bits + 2 && g < 500) begin @(negedge ico_clk); g++; end
      if (g >= 500) timeout("busy shift start");
      tx_valid = 1'b1; tx_data = 8'h77;
      chk("busy tx_ready in SHIFT", tx_ready, 1'b0);
      chk("busy flag in SHIFT", busy, 1'b1);
      @(negedge ico_clk);
      tx_valid = 1'b0;
      wait_ready("busy end");
      repeat (20) @(negedge ico_clk);
      chk("busy mosi bit count", mosi_bits.size() - b_bits, 8);
      if (mosi_bits.size() >= b_bits + 8) begin
         got = '0;
         for (int i = 0; i < 8; i++) got = {got[6:0], mosi_bits[b_bits+i]};
         chk("busy mosi byte", got, 8'hA5);
      end
      chk("busy rejected byte not started", sel_fall_c.size() - b_sf, 1);
      chk("busy idle afterwards", busy, 1'b0);

      b_bits = mosi_bits.size(); b_rx = rx_got.size(); b_sf = sel_fall_c.size();
      @(negedge ico_clk);
      tx_valid = 1'b1; tx_data = 8'hF0; tx_last = 1'b1;
      wait_ready("reset mid");
      @(negedge ico_clk);
      tx_valid = 1'b0;
      g = 0;
      while (mosi_bits.size() < b_bits + 3 && g < 500) begin @(negedge ico_clk); g++; end
      if (g >= 500) timeout("reset mid third rise");
      rst = 1'b1;
      @(negedge ico_clk);
      chk("abort sel", spi_sel, 1'b1);
      chk("abort sclk", spi_sclk, 1'b0);
      chk("abort mosi", spi_mosi, 1'b0);
      chk("abort busy", busy, 1'b0);
      chk("abort tx_ready", tx_ready, 1'b1);
      chk("abort rx_data", rx_data, 8'h00);
      rst = 1'b0;
      repeat (100) @(negedge ico_clk);
      chk("abort no rx_valid", rx_got.size() - b_rx, 0);
      chk("abort no restart", sel_fall_c.size() - b_sf, 1);

      @(negedge ico_clk);
      tx_valid2 = 1'b1; tx_data2 = 8'hC3; tx_last2 = 1'b1;
      g = 0;
      while (!tx_ready2 && g < 500) begin @(negedge ico_clk); g++; end
      t0 = cyc;
      @(negedge ico_clk);
      tx_valid2 = 1'b0;
      g = 0;
      while (!tx_ready2 && g < 500) begin @(negedge ico_clk); g++; end
      if (g >= 500) timeout("div2 tx_ready");
      chk("div2 accept-to-ready cycles", cyc - t0, 1 + 1 + 32 + 1 + 1);
      chk("div2 rx count", rx2_got.size(), 1);
      if (rx2_got.size() > 0) chk("div2 loopback rx_data", rx2_got[0], 8'hC3);
      chk("div2 rise count", rise2.size(), 8);
      g = 0;
      for (int j = 1; j < rise2.size(); j++) if (rise2[j] - rise2[j-1] != 4) g++;
      chk("div2 sclk period", g, 0);
      chk("div2 busy after", busy2, 1'b0);

      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(1, 3);
         stream = 1'($urandom_range(0, 1));
         for (int k = 0; k < 4; k++) begin
            txb[k]  = 8'($urandom);
            rsp[k]  = 8'($urandom);
            gapd[k] = $urandom_range(0, 3);
         end
         run_txn($sformatf("rand%0d", t), n, stream);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
